// File: rtl/bip2_pkg.sv
// bip2_pkg: shared types and decode helpers for the bip2 accumulator core.
// Optional logic/shift instructions are enabled with `define BIP2_LOGIC_EN.
package bip2_pkg;

    localparam int OPC_W = 5;

    typedef enum logic [OPC_W-1:0] {
        OP_HLT  = 5'b00000,
        OP_STO  = 5'b00001,
        OP_LD   = 5'b00010,
        OP_LDI  = 5'b00011,
        OP_ADD  = 5'b00100,
        OP_ADDI = 5'b00101,
        OP_SUB  = 5'b00110,
        OP_SUBI = 5'b00111,
        OP_BEQ  = 5'b01000,
        OP_BNE  = 5'b01001,
        OP_BGT  = 5'b01010,
        OP_BGE  = 5'b01011,
        OP_BLT  = 5'b01100,
        OP_BLE  = 5'b01101,
        OP_JMP  = 5'b01110,
        OP_AND  = 5'b01111,
        OP_ANDI = 5'b10000,
        OP_OR   = 5'b10001,
        OP_ORI  = 5'b10010,
        OP_XOR  = 5'b10011,
        OP_XORI = 5'b10100,
        OP_NOT  = 5'b10101,
        OP_SLL  = 5'b10110,
        OP_SRL  = 5'b10111
    } opcode_e;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        MEM,
        HALT
    } state_e;

    // Branch/jump decision from the current flags; non-branch opcodes never take.
    function automatic logic branch_taken(input opcode_e op, input logic z, input logic n);
        case (op)
            OP_BEQ:  return z;
            OP_BNE:  return !z;
            OP_BGT:  return !n && !z;
            OP_BGE:  return !n;
            OP_BLT:  return n;
            OP_BLE:  return n || z;
            OP_JMP:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Opcodes that need a data-memory access before they can complete.
    function automatic logic is_mem_op(input opcode_e op);
        case (op)
            OP_STO, OP_LD, OP_ADD, OP_SUB: return 1'b1;
`ifdef BIP2_LOGIC_EN
            OP_AND, OP_OR, OP_XOR:         return 1'b1;
`endif
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bip2_alu.sv
// bip2_alu: combinational accumulator datapath. Produces the new ACC value,
// an ACC write enable and the Z/N flags of the result.
// Logic/shift opcodes exist only when BIP2_LOGIC_EN is defined.
module bip2_alu
    import bip2_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0]       acc,
    input  logic [DATA_W-OPC_W-1:0] operand,
    input  logic [DATA_W-1:0]       mdata,
    input  opcode_e                 op,
    output logic [DATA_W-1:0]       result,
    output logic                    wr_en,
    output logic                    zero,
    output logic                    neg
);

    localparam int OPND_W = DATA_W - OPC_W;

    logic [DATA_W-1:0] imm_s;
    assign imm_s = {{OPC_W{operand[OPND_W-1]}}, operand};

`ifdef BIP2_LOGIC_EN
    logic [DATA_W-1:0] imm_z;
    assign imm_z = {{OPC_W{1'b0}}, operand};
`endif

    // Result select per opcode; anything that does not write ACC leaves wr_en low.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        result = acc;
        wr_en  = 1'b0;
        case (op)
            OP_LDI:  begin result = imm_s;         wr_en = 1'b1; end
            OP_ADDI: begin result = acc + imm_s;   wr_en = 1'b1; end
            OP_SUBI: begin result = acc - imm_s;   wr_en = 1'b1; end
            OP_LD:   begin result = mdata;         wr_en = 1'b1; end
            OP_ADD:  begin result = acc + mdata;   wr_en = 1'b1; end
            OP_SUB:  begin result = acc - mdata;   wr_en = 1'b1; end
`ifdef BIP2_LOGIC_EN
            OP_AND:  begin result = acc & mdata;   wr_en = 1'b1; end
            OP_ANDI: begin result = acc & imm_z;   wr_en = 1'b1; end
            OP_OR:   begin result = acc | mdata;   wr_en = 1'b1; end
            OP_ORI:  begin result = acc | imm_z;   wr_en = 1'b1; end
            OP_XOR:  begin result = acc ^ mdata;   wr_en = 1'b1; end
            OP_XORI: begin result = acc ^ imm_z;   wr_en = 1'b1; end
            OP_NOT:  begin result = ~acc;          wr_en = 1'b1; end
            OP_SLL:  begin result = acc << operand[3:0]; wr_en = 1'b1; end
            OP_SRL:  begin result = acc >> operand[3:0]; wr_en = 1'b1; end
`endif
            default: begin result = acc;           wr_en = 1'b0; end
        endcase
    end

    assign zero = (result == '0);
    assign neg  = result[DATA_W-1];

endmodule

// File: rtl/bip2_core.sv
// bip2_core: accumulator processor with FETCH/EXEC/MEM/HALT sequencing and
// req/ready instruction and data ports that tolerate any number of wait states.
// Define BIP2_LOGIC_EN to add the AND/OR/XOR/NOT/shift instructions.
module bip2_core
    import bip2_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ready_i,
    input  logic [DATA_W-1:0] imem_data_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_ready_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] acc_o,
    output logic [1:0]        flags_o,
    output logic              halt_o
);

    localparam int OPND_W = DATA_W - OPC_W;

    if (ADDR_W > OPND_W) begin : g_bad_cfg
        $error("bip2_core: ADDR_W must not exceed DATA_W-5");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              z_q, z_d, n_q, n_d;
    logic              imem_req_q, imem_req_d;
    logic              dmem_req_q, dmem_req_d;
    logic              dmem_we_q, dmem_we_d;

    opcode_e           op;
    logic [OPND_W-1:0] operand;
    logic [DATA_W-1:0] alu_res;
    logic              alu_wr, alu_z, alu_n;

    assign op      = opcode_e'(ir_q[DATA_W-1 -: OPC_W]);
    assign operand = ir_q[OPND_W-1:0];
    assign pc_inc  = pc_q + ADDR_W'(1);

    bip2_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .acc     (acc_q),
        .operand (operand),
        .mdata   (dmem_rdata_i),
        .op      (op),
        .result  (alu_res),
        .wr_en   (alu_wr),
        .zero    (alu_z),
        .neg     (alu_n)
    );

    // Register all architectural state and the request/strobe outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= FETCH;
            pc_q       <= '0;
            acc_q      <= '0;
            ir_q       <= '0;
            z_q        <= 1'b0;
            n_q        <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            state_q    <= state_d;
            pc_q       <= pc_d;
            acc_q      <= acc_d;
            ir_q       <= ir_d;
            z_q        <= z_d;
            n_q        <= n_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
        end
    end

    // Next-state and next-register logic; requests are raised one state ahead so
    // they are already asserted (and stable) on the first cycle of FETCH/MEM.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        acc_d      = acc_q;
        ir_d       = ir_q;
        z_d        = z_q;
        n_d        = n_q;
        imem_req_d = imem_req_q;
        dmem_req_d = dmem_req_q;
        dmem_we_d  = dmem_we_q;
        case (state_q)
            FETCH: begin
                imem_req_d = 1'b1;
                if (imem_req_q && imem_ready_i) begin
                    ir_d       = imem_data_i;
                    imem_req_d = 1'b0;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (op == OP_HLT) begin
                    pc_d    = pc_inc;
                    state_d = HALT;
                end else if (is_mem_op(op)) begin
                    dmem_req_d = 1'b1;
                    dmem_we_d  = (op == OP_STO);
                    state_d    = MEM;
                end else begin
                    pc_d       = branch_taken(op, z_q, n_q) ? operand[ADDR_W-1:0] : pc_inc;
                    imem_req_d = 1'b1;
                    state_d    = FETCH;
                    if (alu_wr) begin
                        acc_d = alu_res;
                        z_d   = alu_z;
                        n_d   = alu_n;
                    end
                end
            end
            MEM: begin
                if (dmem_req_q && dmem_ready_i) begin
                    if (alu_wr) begin
                        acc_d = alu_res;
                        z_d   = alu_z;
                        n_d   = alu_n;
                    end
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    pc_d       = pc_inc;
                    imem_req_d = 1'b1;
                    state_d    = FETCH;
                end
            end
            HALT: begin
                imem_req_d = 1'b0;
                dmem_req_d = 1'b0;
            end
            default: state_d = FETCH;
        endcase
    end

    // Data address and write data come straight from IR/ACC, which cannot change
    // while a data request is outstanding.
    assign imem_req_o   = imem_req_q;
    assign imem_addr_o  = pc_q;
    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = ir_q[ADDR_W-1:0];
    assign dmem_wdata_o = acc_q;
    assign pc_o         = pc_q;
    assign acc_o        = acc_q;
    assign flags_o      = {n_q, z_q};
    assign halt_o       = (state_q == HALT);

endmodule

// File: tb/tb_bip2_core.sv
// tb_bip2_core: program-driven bench for bip2_core with wait-state memory
// models; fetch addresses and data writes are checked against scoreboards.
// Expected values follow BIP2_LOGIC_EN when it is defined.
module tb_bip2_core;

    localparam int DW = 16;
    localparam int AW = 11;

    localparam logic [4:0] HLT  = 5'b00000;
    localparam logic [4:0] STO  = 5'b00001;
    localparam logic [4:0] LD   = 5'b00010;
    localparam logic [4:0] LDI  = 5'b00011;
    localparam logic [4:0] ADD  = 5'b00100;
    localparam logic [4:0] ADDI = 5'b00101;
    localparam logic [4:0] SUB  = 5'b00110;
    localparam logic [4:0] SUBI = 5'b00111;
    localparam logic [4:0] BEQ  = 5'b01000;
    localparam logic [4:0] BNE  = 5'b01001;
    localparam logic [4:0] BGT  = 5'b01010;
    localparam logic [4:0] BGE  = 5'b01011;
    localparam logic [4:0] BLT  = 5'b01100;
    localparam logic [4:0] BLE  = 5'b01101;
    localparam logic [4:0] JMP  = 5'b01110;
    localparam logic [4:0] ANDI = 5'b10000;
    localparam logic [4:0] SLL  = 5'b10110;
    localparam logic [4:0] UNDF = 5'b11111;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk_i, rst_i;
    logic          imem_req_o, imem_ready_i;
    logic [AW-1:0] imem_addr_o;
    logic [DW-1:0] imem_data_i;
    logic          dmem_req_o, dmem_we_o, dmem_ready_i;
    logic [AW-1:0] dmem_addr_o;
    logic [DW-1:0] dmem_wdata_o, dmem_rdata_i;
    logic [AW-1:0] pc_o;
    logic [DW-1:0] acc_o;
    logic [1:0]    flags_o;
    logic          halt_o;

    logic [DW-1:0] rom  [0:(1<<AW)-1];
    logic [DW-1:0] dram [0:(1<<AW)-1];
    logic [AW-1:0] exp_fetch [$];
    wr_t           exp_wr [$];

    int n_checks = 0;
    int n_errors = 0;
    int iwait = 0;
    int dwait = 0;
    int stab_err = 0;
    int cyc = 0;

    bip2_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ready_i (imem_ready_i),
        .imem_data_i  (imem_data_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ready_i (dmem_ready_i),
        .dmem_rdata_i (dmem_rdata_i),
        .pc_o         (pc_o),
        .acc_o        (acc_o),
        .flags_o      (flags_o),
        .halt_o       (halt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Cycle counter: rising edges since reset release.
    initial begin
        forever begin
            @(posedge clk_i);
            if (!rst_i) cyc = 0;
            else        cyc = cyc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ins(input logic [4:0] op, input logic [AW-1:0] opnd);
        return {op, opnd};
    endfunction

    // Memory models: drive ready/data on the falling edge, score handshakes and
    // count any change of a request's attributes while it waits.
    initial begin
        int  icnt, dcnt;
        logic ihold, dhold;
        logic [AW-1:0] ihold_addr;
        logic [AW+DW:0] dhold_val;
        wr_t e;
        icnt = 0; dcnt = 0; ihold = 1'b0; dhold = 1'b0;
        ihold_addr = '0; dhold_val = '0;
        imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
        imem_data_i = '0; dmem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            imem_data_i  = rom[imem_addr_o];
            dmem_rdata_i = dram[dmem_addr_o];
            if (!rst_i) begin
                imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
                icnt = 0; dcnt = 0; ihold = 1'b0; dhold = 1'b0;
            end else begin
                if (imem_req_o) begin
                    if (ihold && imem_addr_o != ihold_addr) stab_err++;
                    if (icnt >= iwait) begin
                        imem_ready_i = 1'b1; icnt = 0; ihold = 1'b0;
                        if (exp_fetch.size() == 0) check("fetch_extra", 32'(imem_addr_o), 32'hDEAD);
                        else check("fetch_addr", 32'(imem_addr_o), 32'(exp_fetch.pop_front()));
                    end else begin
                        imem_ready_i = 1'b0; icnt++; ihold = 1'b1; ihold_addr = imem_addr_o;
                    end
                end else begin
                    imem_ready_i = 1'b0; icnt = 0; ihold = 1'b0;
                end
                if (dmem_req_o) begin
                    if (dhold && {dmem_we_o, dmem_addr_o, dmem_wdata_o} != dhold_val) stab_err++;
                    if (dcnt >= dwait) begin
                        dmem_ready_i = 1'b1; dcnt = 0; dhold = 1'b0;
                        if (dmem_we_o) begin
                            if (exp_wr.size() == 0) check("wr_extra", 32'(dmem_addr_o), 32'hDEAD);
                            else begin
                                e = exp_wr.pop_front();
                                check("wr_addr", 32'(dmem_addr_o), 32'(e.addr));
                                check("wr_data", 32'(dmem_wdata_o), 32'(e.data));
                            end
                            dram[dmem_addr_o] = dmem_wdata_o;
                        end
                    end else begin
                        dmem_ready_i = 1'b0; dcnt++; dhold = 1'b1;
                        dhold_val = {dmem_we_o, dmem_addr_o, dmem_wdata_o};
                    end
                end else begin
                    dmem_ready_i = 1'b0; dcnt = 0; dhold = 1'b0;
                end
            end
        end
    end

    // Hold the core in reset, clear memories and scoreboards, check reset outputs.
    task automatic begin_test(input int iw, input int dw);
        rst_i = 1'b0;
        iwait = iw;
        dwait = dw;
        stab_err = 0;
        exp_fetch.delete();
        exp_wr.delete();
        for (int i = 0; i < (1 << AW); i++) begin
            rom[i]  = '0;
            dram[i] = '0;
        end
        @(negedge clk_i);
        check("rst_pc",    32'(pc_o), 0);
        check("rst_acc",   32'(acc_o), 0);
        check("rst_flags", 32'(flags_o), 0);
        check("rst_halt",  32'(halt_o), 0);
        check("rst_reqs",  32'({imem_req_o, dmem_req_o, dmem_we_o}), 0);
    endtask

    task automatic release_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic run_to_halt(input int budget, output int cycles);
        int n;
        n = 0;
        while (!halt_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        cycles = cyc;
        check("halt_reached", 32'(halt_o), 1);
        check("fetch_q_drained", 32'(exp_fetch.size()), 0);
        check("wr_q_drained", 32'(exp_wr.size()), 0);
        check("req_hold_stable", 32'(stab_err), 0);
    endtask

    task automatic push_fetch(input logic [AW-1:0] a);
        exp_fetch.push_back(a);
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic load_basic();
        rom[0] = ins(LDI, 11'd5);
        rom[1] = ins(ADDI, 11'd3);
        rom[2] = ins(STO, 11'h010);
        rom[3] = ins(HLT, 11'd0);
        for (int i = 0; i < 4; i++) push_fetch(AW'(i));
        push_wr(11'h010, 16'h0008);
    endtask

    initial begin
        int cycles;
        logic [DW-1:0] exp_logic;
        rst_i = 1'b0;

        // Basic program, zero-wait memories.
        begin_test(0, 0);
        load_basic();
        release_reset();
        run_to_halt(200, cycles);
        check("t1_cycles", 32'(cycles), 10);
        check("t1_acc",    32'(acc_o), 32'h0008);
        check("t1_flags",  32'(flags_o), 0);

        // Same program with three wait states per fetch.
        begin_test(3, 0);
        load_basic();
        release_reset();
        run_to_halt(200, cycles);
        check("t2_cycles", 32'(cycles), 22);
        check("t2_acc",    32'(acc_o), 32'h0008);
        check("t2_flags",  32'(flags_o), 0);

        // Negative result, taken BLT, untaken BEQ.
        begin_test(0, 0);
        rom[0]      = ins(LDI, 11'd1);
        rom[1]      = ins(SUBI, 11'd2);
        rom[2]      = ins(BLT, 11'h020);
        rom[11'h20] = ins(BEQ, 11'h030);
        rom[11'h21] = ins(STO, 11'h011);
        rom[11'h22] = ins(HLT, 11'd0);
        push_fetch(11'h000); push_fetch(11'h001); push_fetch(11'h002);
        push_fetch(11'h020); push_fetch(11'h021); push_fetch(11'h022);
        push_wr(11'h011, 16'hFFFF);
        release_reset();
        run_to_halt(200, cycles);
        check("t3_acc",   32'(acc_o), 32'hFFFF);
        check("t3_flags", 32'(flags_o), 32'b10);

        // PC wrap through an undefined opcode at 0x7FF.
        begin_test(0, 0);
        rom[11'h000] = ins(BEQ, 11'h005);
        rom[11'h001] = ins(JMP, 11'h7FE);
        rom[11'h7FE] = ins(LDI, 11'h000);
        rom[11'h7FF] = ins(UNDF, 11'h000);
        rom[11'h005] = ins(HLT, 11'h000);
        push_fetch(11'h000); push_fetch(11'h001); push_fetch(11'h7FE);
        push_fetch(11'h7FF); push_fetch(11'h000); push_fetch(11'h005);
        release_reset();
        run_to_halt(200, cycles);
        check("t4_acc",   32'(acc_o), 0);
        check("t4_flags", 32'(flags_o), 32'b01);

        // Reset while a data read is stalled.
        begin_test(0, 1000);
        rom[0] = ins(LDI, 11'h055);
        rom[1] = ins(LD, 11'h010);
        rom[2] = ins(HLT, 11'd0);
        dram[11'h010] = 16'h1234;
        push_fetch(11'h000); push_fetch(11'h001);
        release_reset();
        for (int i = 0; i < 20 && !dmem_req_o; i++) @(negedge clk_i);
        check("t5_dreq_seen", 32'(dmem_req_o), 1);
        check("t5_acc_before", 32'(acc_o), 32'h0055);
        #2 rst_i = 1'b0;
        #1;
        check("t5_dreq_drop", 32'(dmem_req_o), 0);
        check("t5_ireq_low",  32'(imem_req_o), 0);
        check("t5_acc_reset", 32'(acc_o), 0);
        dwait = 0;
        exp_fetch.delete();
        push_fetch(11'h000); push_fetch(11'h001); push_fetch(11'h002);
        release_reset();
        #1;
        check("t5_pc_after", 32'(pc_o), 0);
        check("t5_acc_after", 32'(acc_o), 0);
        run_to_halt(200, cycles);
        check("t5_acc_ld", 32'(acc_o), 32'h1234);
        check("t5_flags",  32'(flags_o), 0);

        // Logic/shift opcodes: real operations or NOPs depending on the build.
        begin_test(0, 0);
        rom[0] = ins(LDI, 11'h0F0);
        rom[1] = ins(ANDI, 11'h03C);
        rom[2] = ins(SLL, 11'd2);
        rom[3] = ins(HLT, 11'd0);
        for (int i = 0; i < 4; i++) push_fetch(AW'(i));
`ifdef BIP2_LOGIC_EN
        exp_logic = 16'h00C0;
`else
        exp_logic = 16'h00F0;
`endif
        release_reset();
        run_to_halt(200, cycles);
        check("t6_acc",   32'(acc_o), 32'(exp_logic));
        check("t6_flags", 32'(flags_o), 0);

        // Memory ALU ops and the remaining branches, with wait states on both ports.
        begin_test(1, 2);
        dram[11'h020] = 16'h0100;
        dram[11'h021] = 16'h0023;
        dram[11'h022] = 16'h0124;
        rom[0]      = ins(LD,   11'h020);
        rom[1]      = ins(ADD,  11'h021);
        rom[2]      = ins(SUB,  11'h022);
        rom[3]      = ins(STO,  11'h023);
        rom[4]      = ins(BGE,  11'h000);
        rom[5]      = ins(ADDI, 11'd1);
        rom[6]      = ins(BLE,  11'h040);
        rom[11'h40] = ins(BGT,  11'h000);
        rom[11'h41] = ins(BNE,  11'h000);
        rom[11'h42] = ins(HLT,  11'd0);
        for (int i = 0; i < 7; i++) push_fetch(AW'(i));
        push_fetch(11'h040); push_fetch(11'h041); push_fetch(11'h042);
        push_wr(11'h023, 16'hFFFF);
        release_reset();
        run_to_halt(400, cycles);
        check("t7_acc",   32'(acc_o), 0);
        check("t7_flags", 32'(flags_o), 32'b01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
